// File: rtl/wb_io_pkg.sv
// wb_io_pkg: register map, ID/reset constants and byte-lane helpers shared by the wb_io_ctrl slice.
// Revision: 1.0
`default_nettype none

package wb_io_pkg;

  // Register groups are indexed by byte offset / 8; adr[2] then selects LO/HI.
  localparam logic [2:0] c_GRP_OUT  = 3'd0;
  localparam logic [2:0] c_GRP_OEB  = 3'd1;
  localparam logic [2:0] c_GRP_IN   = 3'd2;
  localparam logic [2:0] c_GRP_IEN  = 3'd3;
  localparam logic [2:0] c_GRP_RISE = 3'd4;
  localparam logic [2:0] c_GRP_STAT = 3'd5;
  localparam logic [2:0] c_GRP_ID   = 3'd6;

  localparam logic [31:0] c_ID       = 32'h10C0_0001;
  localparam logic [63:0] c_OEB_RST  = '1;
  localparam logic [63:0] c_RISE_RST = '1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = dat[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] wr_word(input logic [63:0] old_w,
                                          input logic        hi,
                                          input logic [3:0]  sel,
                                          input logic [31:0] dat);
    logic [63:0] r;
    r = old_w;
    if (hi) r[63:32] = byte_merge(old_w[63:32], dat, sel);
    else    r[31:0]  = byte_merge(old_w[31:0], dat, sel);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_io_ctrl_if.sv
// wb_io_ctrl_if: Wishbone-B4 classic slave-side bus bundle.
// Revision: 1.0
`default_nettype none

interface wb_io_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

`default_nettype wire

// File: rtl/io_in_cond.sv
// io_in_cond: per-pad 2-flop synchronizer, optional debounce (IO_DEBOUNCE_EN), edge detector.
// Revision: 1.0
`default_nettype none

module io_in_cond #(
  parameter int DB_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_pad,
  input  wire logic i_rise,
  output logic      o_level,
  output logic      o_event
);

  logic r_sync1, r_sync2, r_prev, r_armed;
  logic w_filt;

  // r_armed keeps the first post-reset cycle from reporting an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
      r_prev  <= w_filt;
      r_armed <= 1'b1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int c_CW = $clog2(DB_CYCLES + 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_filt;

  // Counts consecutive cycles the synchronized level disagrees with the filtered one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CW'(DB_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_filt = r_filt;
`else
  localparam int c_unused_db = DB_CYCLES;
  assign w_filt = r_sync2;
`endif

  assign o_level = w_filt;
  assign o_event = r_armed & (w_filt != r_prev) & (w_filt == i_rise);

endmodule

`default_nettype wire

// File: rtl/wb_io_ctrl.sv
// wb_io_ctrl: Wishbone GPIO controller with edge-triggered sticky W1C status and one irq.
// Revision: 1.0 -- IO_DEBOUNCE_EN enables the per-pad debounce filter.
`default_nettype none

module wb_io_ctrl
  import wb_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NIO       = 38,
  parameter int          DB_CYCLES = 16
) (
  input  wire logic           wb_clk_i,
  input  wire logic           wb_rst_i,
  wb_io_ctrl_if.slave         wbs,
  input  wire logic [NIO-1:0] io_in,
  output logic      [NIO-1:0] io_out,
  output logic      [NIO-1:0] io_oeb,
  output logic                irq
);

  logic [NIO-1:0] r_out, r_oeb, r_ien, r_rise, r_stat;
  logic [NIO-1:0] w_lvl, w_evt, w_clr;
  logic           r_ack, r_irq;
  logic [31:0]    r_dat;
  logic           w_req, w_wr, w_hi;
  logic [2:0]     w_grp;
  logic [63:0]    w_rd64;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_unused = ^wbs.wbs_adr_i[1:0];
  assign w_grp    = wbs.wbs_adr_i[5:3];
  assign w_hi     = wbs.wbs_adr_i[2];
  assign w_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack
                  & (wbs.wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  assign w_wr     = w_req & wbs.wbs_we_i;

  for (genvar gi = 0; gi < NIO; gi++) begin : g_in
    io_in_cond #(.DB_CYCLES(DB_CYCLES)) u_cond (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .i_pad   (io_in[gi]),
      .i_rise  (r_rise[gi]),
      .o_level (w_lvl[gi]),
      .o_event (w_evt[gi])
    );
  end

  always_comb begin
    w_rd64 = '0;
    case (w_grp)
      c_GRP_OUT:  w_rd64 = 64'(r_out);
      c_GRP_OEB:  w_rd64 = 64'(r_oeb);
      c_GRP_IN:   w_rd64 = 64'(w_lvl);
      c_GRP_IEN:  w_rd64 = 64'(r_ien);
      c_GRP_RISE: w_rd64 = 64'(r_rise);
      c_GRP_STAT: w_rd64 = 64'(r_stat);
      c_GRP_ID:   w_rd64 = {32'h0, c_ID};
      default:    w_rd64 = '0;
    endcase
    w_rdata = w_hi ? w_rd64[63:32] : w_rd64[31:0];
  end

  assign w_clr = (w_wr && w_grp == c_GRP_STAT)
               ? NIO'(wr_word('0, w_hi, wbs.wbs_sel_i, wbs.wbs_dat_i)) : '0;

  // Writes land on the edge that raises ack, so the new value is visible in the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_out  <= '0;
      r_oeb  <= NIO'(c_OEB_RST);
      r_ien  <= '0;
      r_rise <= NIO'(c_RISE_RST);
      r_stat <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'h0;
      if (w_wr && w_grp == c_GRP_OUT)
        r_out <= NIO'(wr_word(64'(r_out), w_hi, wbs.wbs_sel_i, wbs.wbs_dat_i));
      if (w_wr && w_grp == c_GRP_OEB)
        r_oeb <= NIO'(wr_word(64'(r_oeb), w_hi, wbs.wbs_sel_i, wbs.wbs_dat_i));
      if (w_wr && w_grp == c_GRP_IEN)
        r_ien <= NIO'(wr_word(64'(r_ien), w_hi, wbs.wbs_sel_i, wbs.wbs_dat_i));
      if (w_wr && w_grp == c_GRP_RISE)
        r_rise <= NIO'(wr_word(64'(r_rise), w_hi, wbs.wbs_sel_i, wbs.wbs_dat_i));
      // A new edge outranks a simultaneous clear of the same bit.
      r_stat <= (r_stat & ~w_clr) | w_evt;
      r_irq  <= |(r_stat & r_ien);
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign io_out        = r_out;
  assign io_oeb        = r_oeb;
  assign irq           = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_io_ctrl.sv
// tb_wb_io_ctrl: directed self-checking bench for wb_io_ctrl.
// Revision: 1.0
`default_nettype none

module tb_wb_io_ctrl;

  localparam logic [31:0] c_BASE = 32'h3000_0000;
`ifdef IO_DEBOUNCE_EN
  localparam int c_LAT = 19;
`else
  localparam int c_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] io_in;
  logic [37:0] io_out, io_oeb;
  logic        irq;
  int          n_tests = 0;
  int          n_fail  = 0;

  wb_io_ctrl_if bus();

  wb_io_ctrl #(.BASE_ADDR(c_BASE), .NIO(38), .DB_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_drop();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  // Returns in the ack cycle, with the bus already released.
  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    idle(1);
    bus_drive(we, c_BASE + 32'(off), dat, sel);
    idle(1);
    chk(we ? "wr_ack" : "rd_ack", 64'(bus.wbs_ack_o), 64'd1);
    rd = bus.wbs_dat_o;
    bus_drop();
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    xfer(1'b1, off, dat, sel, d);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b0, off, 32'h0, 4'hF, d);
    chk(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    int acks;
    rst   = 1'b1;
    io_in = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus_drop();
    idle(3);
    rst = 1'b0;

    chk("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
    chk("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
    chk("rst_out", 64'(io_out), 64'd0);
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_irq", 64'(irq), 64'd0);

    // Held strobe: ack pulses every other cycle, data is zero between acks.
    idle(1);
    bus_drive(1'b0, c_BASE + 32'h30, 32'h0, 4'hF);
    chk("ack_req_cyc", 64'(bus.wbs_ack_o), 64'd0);
    idle(1);
    chk("ack_first", 64'(bus.wbs_ack_o), 64'd1);
    chk("id_data", 64'(bus.wbs_dat_o), 64'h10C0_0001);
    idle(1);
    chk("ack_gap", 64'(bus.wbs_ack_o), 64'd0);
    chk("dat_gap", 64'(bus.wbs_dat_o), 64'd0);
    idle(1);
    chk("ack_b2b", 64'(bus.wbs_ack_o), 64'd1);
    bus_drop();

    wb_rd_chk("oeb_lo", 8'h08, 32'hFFFF_FFFF);
    wb_rd_chk("oeb_hi", 8'h0C, 32'h0000_003F);
    wb_rd_chk("rise_hi", 8'h24, 32'h0000_003F);
    wb_rd_chk("rsvd_34", 8'h34, 32'h0);
    wb_rd_chk("rsvd_3c", 8'h3C, 32'h0);

    wb_wr(8'h00, 32'hA5A5_A5A5, 4'b0101);
    idle(1);
    chk("out_lo_sel", 64'(io_out[31:0]), 64'h00A5_00A5);
    wb_wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    wb_rd_chk("out_hi", 8'h04, 32'h0000_003F);
    chk("out_pads", 64'(io_out), 64'h3F_00A5_00A5);
    wb_wr(8'h08, 32'h0000_0000, 4'b0011);
    idle(1);
    chk("oeb_lo_wr", 64'(io_oeb), 64'h3F_FFFF_0000);

    // Outside the 64-byte window: no ack, no write.
    idle(1);
    bus_drive(1'b1, c_BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (bus.wbs_ack_o) acks++;
    end
    bus_drop();
    chk("oow_no_ack", 64'(acks), 64'd0);
    wb_rd_chk("oow_no_write", 8'h00, 32'h00A5_00A5);

    // Rising edge on bit 3 with interrupt enabled.
    wb_wr(8'h18, 32'h0000_0008, 4'hF);
    idle(1);
    io_in[3] = 1'b1;
    idle(c_LAT);
    chk("b3_irq_early", 64'(irq), 64'd0);
    idle(1);
    chk("b3_irq_set", 64'(irq), 64'd1);
    wb_rd_chk("b3_stat", 8'h28, 32'h0000_0008);
    wb_wr(8'h28, 32'h0000_0008, 4'hF);
    chk("b3_irq_ackcyc", 64'(irq), 64'd1);
    idle(1);
    chk("b3_irq_clr", 64'(irq), 64'd0);

    // Falling edge on bit 5 with interrupt disabled.
    wb_wr(8'h20, 32'hFFFF_FFDF, 4'hF);
    io_in[5] = 1'b1;
    idle(c_LAT + 3);
    io_in[5] = 1'b0;
    idle(c_LAT + 3);
    chk("b5_irq_masked", 64'(irq), 64'd0);
    wb_rd_chk("b5_stat", 8'h28, 32'h0000_0020);
    wb_rd_chk("in_lo", 8'h10, 32'h0000_0008);
    wb_wr(8'h18, 32'h0000_0020, 4'hF);
    chk("b5_irq_ackcyc", 64'(irq), 64'd0);
    idle(1);
    chk("b5_irq_set", 64'(irq), 64'd1);
    wb_wr(8'h28, 32'h0000_0020, 4'hF);
    idle(1);
    chk("b5_irq_clr", 64'(irq), 64'd0);
    wb_wr(8'h18, 32'h0000_0000, 4'hF);

    // Bit 7 edge lands on the same edge as its W1C.
    idle(1);
    io_in[7] = 1'b1;
    idle(c_LAT - 2);
    wb_wr(8'h28, 32'h0000_0080, 4'hF);
    wb_rd_chk("b7_set_wins", 8'h28, 32'h0000_0080);
    wb_wr(8'h28, 32'h0000_0080, 4'hF);
    wb_rd_chk("b7_w1c", 8'h28, 32'h0000_0000);

`ifdef IO_DEBOUNCE_EN
    idle(1);
    io_in[0] = 1'b1;
    idle(10);
    io_in[0] = 1'b0;
    idle(30);
    wb_rd_chk("db_glitch", 8'h28, 32'h0000_0000);
    wb_wr(8'h18, 32'h0000_0001, 4'hF);
    idle(1);
    io_in[0] = 1'b1;
    idle(c_LAT);
    chk("db_irq_early", 64'(irq), 64'd0);
    idle(1);
    chk("db_irq_set", 64'(irq), 64'd1);
    io_in[0] = 1'b0;
    wb_rd_chk("db_stat", 8'h28, 32'h0000_0001);
`endif

    // Reset while a write request is pending.
    idle(1);
    bus_drive(1'b1, c_BASE, 32'hFFFF_FFFF, 4'hF);
    rst = 1'b1;
    idle(1);
    chk("rst_mid_ack", 64'(bus.wbs_ack_o), 64'd0);
    chk("rst_mid_out", 64'(io_out), 64'd0);
    chk("rst_mid_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    bus_drop();
    rst = 1'b0;
    wb_rd_chk("rst_rise_lo", 8'h20, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
